// File: rtl/axis_width_conv_gearbox.sv
// axis_width_conv_gearbox
//   Splits each N-bit input word into R = N/M output beats of M bits.
//   A word carries a valid-beat count (tbeats, 0 meaning all R beats).
//   Beats past that count are dropped. Frame markers are mapped onto the
//   first beat (tfirst) and the last valid beat (tlast). Both sides use
//   FWFT-style handshakes: the data is visible while valid is high, and a
//   transfer happens only in a cycle where both valid and next are high.
//
//   Optional build macro: AXIS_WIDTH_CONV_GEARBOX_OUT_REG_EN
//     undefined : m_axis_* come straight from the holding register (latency 1)
//     defined   : a 2-entry skid register drives m_axis_* from flops (latency 2)
//
// Ports
//   clk, rst         : rising-edge clock, asynchronous active-high reset
//   s_axis_tdata     : input word (N bits)
//   s_axis_tfirst    : frame start marker for the input word
//   s_axis_tlast     : frame end marker for the input word
//   s_axis_tbeats    : number of valid beats in the word (0 = R)
//   s_axis_tvalid    : input word present
//   s_axis_tnext     : consume strobe for the current input word
//   m_axis_tdata     : output beat (M bits)
//   m_axis_tfirst    : first beat of a frame
//   m_axis_tlast     : last beat of a frame
//   m_axis_tvalid    : output beat present
//   m_axis_tnext     : downstream consume strobe
module axis_width_conv_gearbox #(
  parameter int N         = 24,
  parameter int M         = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               s_axis_tdata,
  input  logic                       s_axis_tfirst,
  input  logic                       s_axis_tlast,
  input  logic [$clog2(N/M+1)-1:0]   s_axis_tbeats,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tnext,
  output logic [M-1:0]               m_axis_tdata,
  output logic                       m_axis_tfirst,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tnext
);

  localparam int R  = N / M;
  localparam int BW = $clog2(R + 1);
  localparam logic [BW-1:0] R_B   = BW'(R);
  localparam logic [BW-1:0] ONE_B = BW'(1'b1);
  localparam logic [BW-1:0] ZERO_B = {BW{1'b0}};

  generate
    if ((N < M) || ((N % M) != 0)) begin : g_bad_params
      $error("axis_width_conv_gearbox: N must be a multiple of M and N >= M");
    end
  endgenerate

  logic [N-1:0]  hold_q, hold_d;
  logic          full_q, full_d;
  logic [BW-1:0] idx_q, idx_d;
  logic [BW-1:0] k_q, k_d;
  logic          first_q, first_d;
  logic          last_q, last_d;

  logic          last_beat_s;
  logic          g_valid_s, g_first_s, g_last_s, g_ready_s;
  logic [M-1:0]  g_data_s;
  logic [BW-1:0] k_load_s;

  // The holding register is shifted after every beat, so the current beat
  // always sits at a fixed slice (top for MSB-first, bottom otherwise).
  assign last_beat_s = full_q && (idx_q == (k_q - ONE_B));
  assign g_valid_s   = full_q;
  assign g_first_s   = full_q && first_q && (idx_q == ZERO_B);
  assign g_last_s    = last_beat_s && last_q;

  // Selects the current beat from the holding register
  always_comb begin
    g_data_s = {M{1'b0}};
    if (full_q) begin
      if (MSB_FIRST != 0) begin
        g_data_s = hold_q[N-1 -: M];
      end else begin
        g_data_s = hold_q[M-1:0];
      end
    end else begin
      g_data_s = {M{1'b0}};
    end
  end

  // A new word is taken when the holder is empty or its last beat leaves now
  assign s_axis_tnext = s_axis_tvalid && !rst && (!full_q || (last_beat_s && g_ready_s));

  // Effective beat count of the incoming word, clamped to R
  always_comb begin
    k_load_s = R_B;
    if (s_axis_tbeats == ZERO_B) begin
      k_load_s = R_B;
    end else if (s_axis_tbeats > R_B) begin
      k_load_s = R_B;
    end else begin
      k_load_s = s_axis_tbeats;
    end
  end

  // Holding register next state: load on consume, advance on beat transfer
  always_comb begin
    hold_d  = hold_q;
    full_d  = full_q;
    idx_d   = idx_q;
    k_d     = k_q;
    first_d = first_q;
    last_d  = last_q;
    if (s_axis_tnext) begin
      hold_d  = s_axis_tdata;
      full_d  = 1'b1;
      idx_d   = ZERO_B;
      k_d     = k_load_s;
      first_d = s_axis_tfirst;
      last_d  = s_axis_tlast;
    end else if (full_q && g_ready_s) begin
      if (last_beat_s) begin
        // remaining beats of a partial word are simply dropped here
        full_d = 1'b0;
      end else begin
        idx_d = idx_q + ONE_B;
        if (MSB_FIRST != 0) begin
          hold_d = hold_q << M;
        end else begin
          hold_d = hold_q >> M;
        end
      end
    end else begin
      full_d = full_q;
    end
  end

  // Holding register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q  <= {N{1'b0}};
      full_q  <= 1'b0;
      idx_q   <= ZERO_B;
      k_q     <= ZERO_B;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      full_q  <= full_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

`ifdef AXIS_WIDTH_CONV_GEARBOX_OUT_REG_EN
  // Two-entry skid: out_q is what the consumer sees, skid_q catches the beat
  // that was already in flight when the consumer stalled.
  logic [M+1:0] out_q, out_d, skid_q, skid_d;
  logic         out_v_q, out_v_d, skid_v_q, skid_v_d;
  logic         pop_s, push_s;

  assign g_ready_s = !skid_v_q;
  assign pop_s     = out_v_q && m_axis_tnext;
  assign push_s    = g_valid_s && g_ready_s;

  // Skid register next state
  always_comb begin
    out_d    = out_q;
    out_v_d  = out_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (skid_v_q) begin
      if (pop_s) begin
        out_d    = skid_q;
        skid_v_d = 1'b0;
      end else begin
        out_d = out_q;
      end
    end else if (push_s) begin
      if (!out_v_q || pop_s) begin
        out_d   = {g_first_s, g_last_s, g_data_s};
        out_v_d = 1'b1;
      end else begin
        skid_d   = {g_first_s, g_last_s, g_data_s};
        skid_v_d = 1'b1;
      end
    end else if (pop_s) begin
      out_v_d = 1'b0;
    end else begin
      out_v_d = out_v_q;
    end
  end

  // Skid register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= {(M+2){1'b0}};
      out_v_q  <= 1'b0;
      skid_q   <= {(M+2){1'b0}};
      skid_v_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      out_v_q  <= out_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign m_axis_tvalid = out_v_q;
  assign m_axis_tfirst = out_q[M+1];
  assign m_axis_tlast  = out_q[M];
  assign m_axis_tdata  = out_q[M-1:0];
`else
  assign g_ready_s     = m_axis_tnext;
  assign m_axis_tvalid = g_valid_s;
  assign m_axis_tfirst = g_first_s;
  assign m_axis_tlast  = g_last_s;
  assign m_axis_tdata  = g_data_s;
`endif

endmodule

// File: doc/axis_width_conv_gearbox.md
AXIS_WIDTH_CONV_GEARBOX -- requirements
Module: axis_width_conv_gearbox

Interface
REQ-001 SHALL have parameter N, default 24, input word width in bits.
REQ-002 SHALL have parameter M, default 8, output beat width in bits; R = N/M beats per word.
REQ-003 SHALL have parameter MSB_FIRST, default 1; 1 emits bits [N-1 -: M] first, 0 emits bits [M-1:0] first.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port s_axis_tdata, input, N, input word.
REQ-007 SHALL have port s_axis_tfirst, input, 1, frame start marker.
REQ-008 SHALL have port s_axis_tlast, input, 1, frame end marker.
REQ-009 SHALL have port s_axis_tbeats, input, $clog2(R+1), number of valid beats in the word; 0 means R.
REQ-010 SHALL have port s_axis_tvalid, input, 1, input word present (FWFT style).
REQ-011 SHALL have port s_axis_tnext, output, 1, consume strobe for the current input word.
REQ-012 SHALL have ports m_axis_tdata (output, M), m_axis_tfirst (output, 1), m_axis_tlast (output, 1), and m_axis_tvalid (output, 1).
REQ-013 SHALL have port m_axis_tnext, input, 1, downstream consume strobe.

Function
REQ-014 SHALL fail elaboration ($error) unless N >= M and N % M == 0.
REQ-015 SHALL consume an input word only in cycles where s_axis_tvalid && s_axis_tnext; s_axis_tnext SHALL never be high while s_axis_tvalid is low.
REQ-016 SHALL complete an output transfer only in cycles where m_axis_tvalid && m_axis_tnext; m_axis_tnext while m_axis_tvalid is low SHALL be ignored.
REQ-017 SHALL drive s_axis_tnext combinationally = s_axis_tvalid && !rst && (holding register empty || (last valid beat held && m_axis_tnext)).
REQ-018 SHALL load the word into a holding register on consume, set beat index 0, and latch K = (tbeats==0 ? R : min(tbeats,R)).
REQ-019 SHALL present beat i (0..K-1) in the order selected by MSB_FIRST; m_axis_tdata SHALL hold stable while m_axis_tvalid && !m_axis_tnext.
REQ-020 SHALL assert m_axis_tfirst only on beat 0 of a word loaded with s_axis_tfirst=1.
REQ-021 SHALL assert m_axis_tlast only on beat K-1 of a word loaded with s_axis_tlast=1.
REQ-022 SHALL discard beats K..R-1 of a partial word; they are never emitted.
REQ-023 SHALL make the first beat visible the cycle after consume (latency 1) without the output register.
REQ-024 SHALL sustain one beat per cycle with m_axis_tnext held high, including across word boundaries, with no bubble cycles.
REQ-025 SHALL treat R == 1 as a registered pass-through with identical handshake rules.

Reset
REQ-026 SHALL, while rst is high, force m_axis_tvalid=0, m_axis_tdata=0, m_axis_tfirst=0, m_axis_tlast=0, s_axis_tnext=0, and zero the beat index and K.
REQ-027 SHALL discard any partially emitted word when rst is asserted mid-operation and emit nothing from it after release.
REQ-028 SHALL allow the first consume in the first clock edge after rst deasserts.

Configuration
REQ-029 SHALL, with macro AXIS_WIDTH_CONV_GEARBOX_OUT_REG_EN defined, insert a 2-entry skid output register: latency 2, full throughput, and m_axis_* driven directly from flops.
REQ-030 SHALL, without AXIS_WIDTH_CONV_GEARBOX_OUT_REG_EN, drive m_axis_* from the holding register/mux with latency 1; the observable beat sequence SHALL be identical in both builds.

Verification
REQ-031 SHALL verify: N=24, M=8, MSB_FIRST=1, word 0xA1B2C3, tfirst=1, tbeats=0 -> beats A1(first), B2, C3.
REQ-032 SHALL verify: same word with MSB_FIRST=0 -> C3(first), B2, A1.
REQ-033 SHALL verify: word 0xA1B2C3, tbeats=2, tlast=1 -> A1, B2(last); C3 is never output; the next word follows immediately.
REQ-034 SHALL verify: m_axis_tnext low for 3 cycles on beat A1 -> A1 held stable with m_axis_tvalid=1, s_axis_tnext=0, and no beat lost.
REQ-035 SHALL verify: 2048 random words through an FWFT FIFO with tfirst on words 0, 4 and 5, and m_axis_tnext=m_axis_tvalid -> 6144 beats matching the model, with no idle cycle after the first beat.
REQ-036 SHALL verify: rst pulsed after beat B2 of 0xA1B2C3 -> all outputs 0 during reset, C3 never emitted, and the next word's first beat output correctly.
